fetch_unit: RTL

- Instruction-fetch front end for the single-cycle RISC-V core. Sits directly upstream of the combinational instruction memory.
- Owns the program counter and drives the byte address to InstMem. Captures the returned 32-bit word into a small prefetch queue.
- Presents {instruction, pc} pairs to decode with a valid/ready handshake.
- Accepts a redirect (branch/jump target) that flushes the queue and restarts fetch.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_unit_if.sv | 32 +++
 rtl/fetch_fifo.sv | 75 +++++++
 rtl/fetch_unit.sv | 92 +++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package fetch_pkg;

  localparam int ADDR_W      = 8;
  localparam int INSTR_W     = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;

  // One prefetched instruction together with the byte address it came from.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  // Fetch targets are word aligned; the two low address bits are dropped.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus between the fetch unit, the instruction memory and decode.
// master = fetch unit side, slave = memory/decode side.
interface fetch_unit_if #(
  parameter int ADDR_W = fetch_pkg::ADDR_W
) ();

  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_instr;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_pc;

  modport master (
    output imem_addr,
    input  imem_instr,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small prefetch queue of fetch entries. Flush empties the queue in one
// cycle and wins over push/pop. The head is the raw entry at rd_ptr; the
// caller decides what to show when the queue is empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  fetch_entry_t       push_data,
  output logic               full,
  output logic               empty,
  output logic [CNT_W-1:0]   count,
  output fetch_entry_t       head
);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next queue state: flush resets pointers, otherwise push/pop move them.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Queue registers; storage is cleared on reset so nothing reads as X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, reads the combinational
// instruction memory and queues {instr, pc} pairs for decode.
// Optional feature macro: FETCH_STALL_CNT_EN adds a saturating 16-bit
// count of cycles where decode held back a valid head.
// ADDR_W must match fetch_pkg::ADDR_W since queue entries use the package type.
module fetch_unit #(
  parameter int                DEPTH    = 2,
  parameter int                ADDR_W   = fetch_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  fetch_unit_if.master      bus
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0]     pc_q, pc_d;
  logic                  push, pop, out_valid;
  logic                  fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  fetch_pkg::fetch_entry_t new_entry, head;

  assign out_valid = (fifo_count != '0) && !redirect;
  assign pop       = out_valid && bus.out_ready;
  assign push      = fetch_en && !redirect && (!fifo_full || pop);

  assign new_entry.instr = bus.imem_instr;
  assign new_entry.pc    = pc_q;

  assign bus.imem_addr = pc_q;
  assign bus.out_valid = out_valid;
  assign bus.out_instr = fifo_empty ? '0 : head.instr;
  assign bus.out_pc    = fifo_empty ? '0 : head.pc;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .flush     (redirect),
    .push_data (new_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (head)
  );

  // Next PC: redirect target wins, otherwise step one word per push (wraps).
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = fetch_pkg::align_pc(redirect_pc);
    end else if (push) begin
      pc_d = pc_q + ADDR_W'(fetch_pkg::INSTR_BYTES);
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Count cycles where a head is waiting but decode is not ready; saturate.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((fifo_count != '0) && !bus.out_ready && !redirect && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Stall counter register, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
